alu_exec: RTL
=============

// Module: alu_exec
// PURPOSE
//  Execute/write-back stage directly downstream of the 4x8 register file.
//  - Consumes the two read ports (A = R[inst[11:10]], B = R[inst[9:8]]) and the current 16-bit instruction.
//  - Produces the write-back byte and write enable for R[inst[11:10]], plus Z/C flags.
//  - Raises stall so fetch holds inst until write-back completes.
//  - Single-cycle ops take 2 cycles; MUL/MULH use an 8-step iterative multiplier.
// PARAMETERS
//  DW     8    datapath width; must match register file data width
//  MUL_N  8    multiplier iterations; equals DW
// PORTS
//  clk         in   1    system clock; all state updates on posedge
//  rst         in   1    synchronous, active-high reset
//  inst        in   16   current instruction: [15:12] opcode, [11:10] ra, [9:8] rb, [7:0] imm
//  inst_valid  in   1    inst is a real instruction this cycle
//  reg_data1   in   DW   R[ra] from register file
//  reg_data2   in   DW   R[rb] from register file
//  wb_data     out  DW   write-back value (to register file data)
//  wb_en       out  1    write enable (to register file reg_en); one-cycle pulse
//  stall       out  1    fetch must hold PC/inst while high
//  flag_z      out  1    zero flag from last write-back
//  flag_c      out  1    carry/borrow/shift-out flag from last write-back
// BEHAVIOUR
//  Opcodes:
//   0 NOP; 1 ADD; 2 SUB (A-B); 3 AND; 4 OR; 5 XOR; 6 NOT A;
//   7 SHL A by 1; 8 SHR A by 1 (logical); 9 LDI imm;
//   A MUL (low byte of A*B); B MULH (high byte of A*B); C-F treated as NOP.
//  States: IDLE, MUL, WB.
//  IDLE:
//   - inst_valid=0, or opcode is NOP/C-F: nothing happens; stall=0, wb_en=0.
//   - inst_valid=1 and a writing op: stall=1 combinationally (cycle 0); latch A, B, imm, opcode.
//   - Single-cycle op: compute result and flags into holding regs; next state WB.
//   - MUL/MULH: load multiplier and clear its step counter; next state MUL.
//  MUL: stall=1; one shift-add step per cycle; after MUL_N steps -> WB.
//   - Computed on latched operands; inst_valid and reg_data changes are ignored.
//  WB: wb_en=1, wb_data=result, stall=0; flags update at end of cycle; -> IDLE.
//   - inst is still unchanged here, so the register file writes the correct ra.
//   - Fetch advances at the end of this cycle.
//  Latency:
//   - Single-cycle op: wb_en in cycle 1 after accept; stall high 1 cycle.
//   - MUL/MULH: wb_en in cycle MUL_N+1 (9); stall high 9 cycles.
//  Arithmetic:
//   - ADD: C = bit DW carry-out.
//   - SUB: C = borrow (A<B).
//   - SHL: C = A[7]. SHR: C = A[0].
//   - LDI, logic ops: C=0.
//   - MUL/MULH: full 16-bit product; C = |product[15:8] for MUL, C=0 for MULH.
//   - Z = (result==0) for every writing op.
//   - All results truncate to DW; no saturation.
//  Reset (rst=1 at a posedge), including mid-MUL or in WB:
//   - State -> IDLE; wb_en=0, wb_data=0, flag_z=0, flag_c=0.
//   - Multiplier cleared; no partial write-back is ever issued.
//   - stall=0 while rst is high.
//  Back-to-back: a new accept is possible in the cycle after WB (no bubble beyond WB).
// STRUCTURE
//  cpu_pkg (shared):
//   - opcode localparams OP_NOP..OP_MULH
//   - state encoding ST_IDLE/ST_MUL/ST_WB
//   - field slices OPC_MSB/LSB, RA_MSB/LSB, RB_MSB/LSB
//   - DW default
//  Sub-module mul_seq8:
//   - ports clk, rst, start, a, b -> busy, done, product[2*DW-1:0]
//   - iterative shift-add, MUL_N cycles
//  alu_exec contains: FSM, single-cycle ALU, result/flag regs, stall logic.
// TESTING
//  1 ADD, A=0xF0 B=0x20 -> stall=1 cycle 0; cycle 1 wb_en=1, wb_data=0x10, C=1, Z=0.
//  2 SUB, A=0x05 B=0x05 -> wb_data=0x00, Z=1, C=0. SUB A=0x03 B=0x04 -> wb_data=0xFF, C=1.
//  3 MUL, A=0x0F B=0x11 -> stall high 9 cycles; cycle 9 wb_en=1, wb_data=0xFF, C=0.
//    MULH, A=0xFF B=0xFF -> wb_data=0xFE, C=0.
//  4 rst pulsed during MUL step 4 -> next cycle IDLE, stall=0; wb_en never asserted; flags 0.
//  5 NOP with inst_valid=1 -> stall=0, wb_en=0, flags unchanged.
//    LDI imm=0x5A -> wb_data=0x5A, Z=0, C=0.
//  6 Back-to-back: SHL A=0x81 then SHR A=0x01 -> wb 0x02 C=1, then wb 0x00 Z=1 C=1;
//    wb_en pulses exactly twice.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM encoding and instruction field positions for the execute stage.
package cpu_pkg;

  localparam int unsigned DEF_DW = 8;
  localparam int unsigned INST_W = 16;

  // Instruction field slices
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RA_MSB  = 11;
  localparam int unsigned RA_LSB  = 10;
  localparam int unsigned RB_MSB  = 9;
  localparam int unsigned RB_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_MULH = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // True for every opcode that produces a register write-back (C-F behave as NOP).
  function automatic logic op_writes(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_MULH);
  endfunction

  function automatic logic op_is_mul(input logic [3:0] opc);
    return (opc == OP_MUL) || (opc == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_seq8.sv
// Iterative shift-add multiplier: one partial product per cycle, MUL_N steps per operation.
module mul_seq8
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned MUL_N = DW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*DW-1:0] o_product
);

  localparam int unsigned CW = (MUL_N > 1) ? $clog2(MUL_N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_N - 1);

  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DW{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) begin
        r_busy <= 1'b0;
      end
    end
  end

  // done flags the cycle performing the final step; the product is valid the cycle after.
  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST_STEP);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_exec.sv
// Execute/write-back stage: single-cycle ALU, sequential multiplier, flags and fetch stall.
module alu_exec
  import cpu_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned MUL_N = DW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_inst_valid,
  input  logic [DW-1:0]     i_reg_data1,
  input  logic [DW-1:0]     i_reg_data2,
  output logic [DW-1:0]     o_wb_data,
  output logic              o_wb_en,
  output logic              o_stall,
  output logic              o_flag_z,
  output logic              o_flag_c
);

  state_e          r_state;
  logic [DW-1:0]   r_result;
  logic            r_c;
  logic            r_is_mul;
  logic            r_mulh;
  logic            r_flag_z;
  logic            r_flag_c;

  logic [3:0]      w_opc;
  logic            w_accept;
  logic            w_mul_start;
  logic            w_mul_done;
  logic [2*DW-1:0] w_product;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_diff;
  logic [DW-1:0]   w_alu_res;
  logic            w_alu_c;
  logic [DW-1:0]   w_wb_value;
  logic            w_wb_c;
  logic            w_unused_regsel;
  logic            w_unused_mul_busy;

  assign w_opc       = i_inst[OPC_MSB:OPC_LSB];
  assign w_accept    = (r_state == ST_IDLE) && i_inst_valid && op_writes(w_opc);
  assign w_mul_start = w_accept && op_is_mul(w_opc);

  // Register selects are consumed by the register file, not here.
  assign w_unused_regsel = ^i_inst[RA_MSB:RB_LSB];

  mul_seq8 #(
    .DW    (DW),
    .MUL_N (MUL_N)
  ) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_mul_start),
    .i_a       (i_reg_data1),
    .i_b       (i_reg_data2),
    .o_busy    (w_unused_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // Single-cycle ALU evaluated on the live register-file operands at accept time.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_sum     = {1'b0, i_reg_data1} + {1'b0, i_reg_data2};
    w_diff    = {1'b0, i_reg_data1} - {1'b0, i_reg_data2};
    case (w_opc)
      OP_ADD: begin
        w_alu_res = w_sum[DW-1:0];
        w_alu_c   = w_sum[DW];
      end
      OP_SUB: begin
        w_alu_res = w_diff[DW-1:0];
        w_alu_c   = w_diff[DW];  // borrow out when A < B
      end
      OP_AND: w_alu_res = i_reg_data1 & i_reg_data2;
      OP_OR:  w_alu_res = i_reg_data1 | i_reg_data2;
      OP_XOR: w_alu_res = i_reg_data1 ^ i_reg_data2;
      OP_NOT: w_alu_res = ~i_reg_data1;
      OP_SHL: begin
        w_alu_res = {i_reg_data1[DW-2:0], 1'b0};
        w_alu_c   = i_reg_data1[DW-1];
      end
      OP_SHR: begin
        w_alu_res = {1'b0, i_reg_data1[DW-1:1]};
        w_alu_c   = i_reg_data1[0];
      end
      OP_LDI: w_alu_res = DW'(i_inst[IMM_MSB:IMM_LSB]);
      default: begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
      end
    endcase
  end

  // Select the value being written back: held ALU result or the finished product.
  always_comb begin
    w_wb_value = r_result;
    w_wb_c     = r_c;
    if (r_is_mul) begin
      if (r_mulh) begin
        w_wb_value = w_product[2*DW-1:DW];
        w_wb_c     = 1'b0;
      end else begin
        w_wb_value = w_product[DW-1:0];
        w_wb_c     = |w_product[2*DW-1:DW];
      end
    end
  end

  // Control FSM with holding registers and flags; flags commit at the end of write-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_c      <= 1'b0;
      r_is_mul <= 1'b0;
      r_mulh   <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (op_is_mul(w_opc)) begin
              r_is_mul <= 1'b1;
              r_mulh   <= (w_opc == OP_MULH);
              r_state  <= ST_MUL;
            end else begin
              r_is_mul <= 1'b0;
              r_mulh   <= 1'b0;
              r_result <= w_alu_res;
              r_c      <= w_alu_c;
              r_state  <= ST_WB;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_done) begin
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_flag_z <= (w_wb_value == '0);
          r_flag_c <= w_wb_c;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall fetch from the accept cycle until write-back; reset always releases it.
  always_comb begin
    o_stall = 1'b0;
    if (!i_rst) begin
      o_stall = w_accept || (r_state == ST_MUL);
    end
  end

  assign o_wb_en   = (r_state == ST_WB) && !i_rst;
  assign o_wb_data = (r_state == ST_WB) ? w_wb_value : '0;
  assign o_flag_z  = r_flag_z;
  assign o_flag_c  = r_flag_c;

endmodule
